control_unit: RTL and testbench
===============================

# control_unit

Multi-cycle control sequencer for the RISC CPU datapath. Steps every instruction through fetch (T0–T2) and an opcode-specific execute sequence (T3–T7), driving the register-file, bus-source, latch and memory strobes. It consumes the 5-bit opcode from the instruction register and the branch condition flip-flop. It handles halt, external stop and memory wait.

## Interface
Parameters:
- none

Ports:
- Clock  in  1  system clock; all state changes on rising edge
- Clear  in  1  synchronous, active-high reset
- Opcode  in  5  IR[31:27], valid from T3 onward
- CON  in  1  branch condition flip-flop output
- Stop  in  1  external halt request
- MemReady  in  1  memory read/write complete
- Run  out  1  high while not halted
- PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout  out  1 each  bus source selects; at most one high per cycle
- PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPortin, CONin  out  1 each  register load enables
- Gra, Grb, Grc, Rin, Rout  out  1 each  register-file field select and access strobes
- IncPC, Read, Write  out  1 each  PC increment and memory strobes
- ALUop  out  5  ALU operation code

## Operation
- States: IDLE, T0–T7, HALT.
- All outputs are Moore-decoded from state and latched Opcode.
- Any strobe not listed for a step is 0.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Execute by opcode class:
  - R-format (00011–01011):
    - T3: Grb, Rout, Yin.
    - T4: Grc, Rout, Zin, ALUop=Opcode.
    - T5: Zlowout, Gra, Rin.
  - addi/andi/ori (01100–01110):
    - T3: Grb, Rout, Yin.
    - T4: Cout, Zin, ALUop=Opcode.
    - T5: Zlowout, Gra, Rin.
  - ld (00000):
    - T3: Grb, BAout, Yin.
    - T4: Cout, Zin, ALUop=ADD.
    - T5: Zlowout, MARin.
    - T6: Read, MDRin.
    - T7: MDRout, Gra, Rin.
  - ldi (00001): as ld T3–T4, then T5: Zlowout, Gra, Rin.
  - st (00010):
    - T3–T5 as ld.
    - T6: Gra, Rout, MDRin.
    - T7: Write.
  - mul/div (01111, 10000):
    - T3: Gra, Rout, Yin.
    - T4: Grb, Rout, Zin, ALUop.
    - T5: Zlowout, LOin.
    - T6: Zhighout, HIin.
  - neg/not (10001, 10010):
    - T3: Grb, Rout, Zin, ALUop.
    - T4: Zlowout, Gra, Rin.
  - br (10011):
    - T3: Gra, Rout, CONin.
    - T4: PCout, Yin.
    - T5: Cout, Zin, ALUop=ADD.
    - T6: if CON=1, Zlowout and PCin; else no strobes.
  - jr (10100): T3: Gra, Rout, PCin.
  - jal (10101):
    - T3: PCout, Grb, Rin (link register).
    - T4: Gra, Rout, PCin.
  - in: T3 InPortout, Gra, Rin.
  - out: T3 Gra, Rout, OutPortin.
  - mfhi: T3 HIout, Gra, Rin.
  - mflo: T3 LOout, Gra, Rin.
  - nop (11010) and undefined opcodes: no execute steps; return to T0.
  - halt (11011): enter HALT.
- The last execute step of every class goes to T0 next cycle.
- ALUop is 0 outside ALU steps. ADD = 00011.
- HALT: all strobes 0, Run=0. Leaves only on Clear.
- Stop sampled in T0 only: if Stop=1 in T0, T0 strobes still issue and next state is HALT. Stop in other states is ignored.

## Timing
- Clear: next state IDLE. IDLE has all strobes 0, Run=1, and goes to T0 next cycle.
- Clear overrides every state, including mid-instruction and HALT.
- Clear during a memory wait aborts the access; Read/Write drop the cycle after.
- Cycle counts, excluding memory wait:
  - R-format/immediate: 6.
  - ld/st: 8.
  - mul/div: 7.
  - br: 7.
  - jr, in, out, mfhi, mflo: 4.
  - jal: 5.
  - nop: 3.
- Opcode is sampled at end of T2 into an internal register.
- An IR change after T2 does not alter the current sequence.

## Configuration
- CU_MEMWAIT_EN defined: states asserting Read or Write (T1, ld T6, st T7) hold, with strobes held, until MemReady=1. The state advances on the edge where MemReady=1.
- CU_MEMWAIT_EN undefined: memory steps last one cycle; MemReady ignored.

## Structure
- Shared package cpu_pkg:
  - opcode constants for all 28 opcodes
  - ALU_ADD constant
  - state enum (IDLE, T0–T7, HALT)
- Single module, no sub-module; state register and Moore output decode in one file.

## Test plan
- Clear=1 for 2 cycles, release → one IDLE cycle with all strobes 0 and Run=1; then T0 with PCout=MARin=IncPC=Zin=1.
- Opcode=00011 (add), MemReady tied 1 → T3 Grb+Rout+Yin; T4 Grc+Rout+Zin with ALUop=00011; T5 Zlowout+Gra+Rin; T0 at cycle 7.
- br with CON=0 → T6 has no strobes, PCin never asserted. Same with CON=1 → T6 Zlowout+PCin.
- CU_MEMWAIT_EN, ld, MemReady low 3 cycles in T6 → Read and MDRin held 4 cycles; T7 follows the MemReady=1 edge.
- Opcode=11011 → HALT, Run=0, all strobes 0 for 20 cycles. Clear → IDLE.
- Stop=1 during T4 then released → ignored. Stop=1 in T0 → T0 strobes issue, then HALT.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode map, ALU constant, sequencer state and opcode classes for the control unit
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        C_RFMT, C_IMM, C_LD, C_LDI, C_ST, C_MULDIV, C_UNARY, C_BR,
        C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NONE, C_HALT
    } class_e;

    // Group an opcode into the execute sequence it follows; anything unlisted behaves as nop.
    function automatic class_e op_class(input logic [4:0] op);
        class_e c;
        c = C_NONE;
        if (op == OP_LD)         c = C_LD;
        else if (op == OP_LDI)   c = C_LDI;
        else if (op == OP_ST)    c = C_ST;
        else if (op <= OP_ROL)   c = C_RFMT;
        else if (op <= OP_ORI)   c = C_IMM;
        else if (op <= OP_DIV)   c = C_MULDIV;
        else if (op <= OP_NOT)   c = C_UNARY;
        else if (op == OP_BR)    c = C_BR;
        else if (op == OP_JR)    c = C_JR;
        else if (op == OP_JAL)   c = C_JAL;
        else if (op == OP_IN)    c = C_IN;
        else if (op == OP_OUT)   c = C_OUT;
        else if (op == OP_MFHI)  c = C_MFHI;
        else if (op == OP_MFLO)  c = C_MFLO;
        else if (op == OP_HALT)  c = C_HALT;
        return c;
    endfunction

    // Index (3..7) of the final execute step for a class; after it the sequencer refetches.
    function automatic logic [2:0] last_step(input class_e c);
        logic [2:0] s;
        case (c)
            C_RFMT, C_IMM, C_LDI: s = 3'd5;
            C_LD, C_ST:           s = 3'd7;
            C_MULDIV, C_BR:       s = 3'd6;
            C_UNARY, C_JAL:       s = 3'd4;
            default:              s = 3'd3;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle fetch/execute sequencer; CU_MEMWAIT_EN adds MemReady stalls on memory steps
module control_unit
    import cpu_pkg::*;
(
    input  logic       Clock,
    input  logic       Clear,
    input  logic [4:0] Opcode,
    input  logic       CON,
    input  logic       Stop,
    input  logic       MemReady,
    output logic       Run,
    output logic       PCout,
    output logic       Zlowout,
    output logic       Zhighout,
    output logic       MDRout,
    output logic       HIout,
    output logic       LOout,
    output logic       InPortout,
    output logic       Cout,
    output logic       BAout,
    output logic       PCin,
    output logic       IRin,
    output logic       MARin,
    output logic       MDRin,
    output logic       Yin,
    output logic       Zin,
    output logic       HIin,
    output logic       LOin,
    output logic       OutPortin,
    output logic       CONin,
    output logic       Gra,
    output logic       Grb,
    output logic       Grc,
    output logic       Rin,
    output logic       Rout,
    output logic       IncPC,
    output logic       Read,
    output logic       Write,
    output logic [4:0] ALUop
);

    state_e     state_q, state_d;
    logic [4:0] opcode_q;
    class_e     cls_cur;
    class_e     cls_in;
    logic [2:0] last_w;
    logic       mem_wait;

    // Execute steps follow the latched opcode; the T2 branch decision uses the value being latched.
    assign cls_cur = op_class(opcode_q);
    assign cls_in  = op_class(Opcode);
    assign last_w  = last_step(cls_cur);

`ifdef CU_MEMWAIT_EN
    assign mem_wait = (Read | Write) & ~MemReady;
`else
    assign mem_wait = 1'b0;
    logic unused_memready;
    assign unused_memready = MemReady;
`endif

    // State and latched opcode; Clear wins over everything, including HALT and pending memory waits.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_T2) begin
                opcode_q <= Opcode;
            end
        end
    end

    // Step sequencing: fetch, opcode-dependent execute length, Stop checked only in T0, memory stalls.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_T0;
            S_T0:   state_d = Stop ? S_HALT : S_T1;
            S_T1:   state_d = S_T2;
            S_T2: begin
                case (cls_in)
                    C_NONE:  state_d = S_T0;
                    C_HALT:  state_d = S_HALT;
                    default: state_d = S_T3;
                endcase
            end
            S_T3:   state_d = (last_w == 3'd3) ? S_T0 : S_T4;
            S_T4:   state_d = (last_w == 3'd4) ? S_T0 : S_T5;
            S_T5:   state_d = (last_w == 3'd5) ? S_T0 : S_T6;
            S_T6:   state_d = (last_w == 3'd6) ? S_T0 : S_T7;
            S_T7:   state_d = S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        if (mem_wait) begin
            state_d = state_q;
        end
    end

    // Moore strobe decode from step and latched opcode class; br T6 additionally gates on CON.
    always_comb begin
        PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0; HIout = 1'b0;
        LOout = 1'b0; InPortout = 1'b0; Cout = 1'b0; BAout = 1'b0;
        PCin = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0; Yin = 1'b0; Zin = 1'b0;
        HIin = 1'b0; LOin = 1'b0; OutPortin = 1'b0; CONin = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
        ALUop = 5'b00000;
        Run = (state_q != S_HALT);
        case (state_q)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                case (cls_cur)
                    C_RFMT, C_IMM:     begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    C_LD, C_LDI, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    C_MULDIV:          begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    C_UNARY:           begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUop = opcode_q; end
                    C_BR:              begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    C_JR:              begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    C_JAL:             begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
                    C_IN:              begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_OUT:             begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
                    C_MFHI:            begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_MFLO:            begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls_cur)
                    C_RFMT:            begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUop = opcode_q; end
                    C_IMM:             begin Cout = 1'b1; Zin = 1'b1; ALUop = opcode_q; end
                    C_LD, C_LDI, C_ST: begin Cout = 1'b1; Zin = 1'b1; ALUop = ALU_ADD; end
                    C_MULDIV:          begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUop = opcode_q; end
                    C_UNARY:           begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_BR:              begin PCout = 1'b1; Yin = 1'b1; end
                    C_JAL:             begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls_cur)
                    C_RFMT, C_IMM, C_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_LD, C_ST:           begin Zlowout = 1'b1; MARin = 1'b1; end
                    C_MULDIV:             begin Zlowout = 1'b1; LOin = 1'b1; end
                    C_BR:                 begin Cout = 1'b1; Zin = 1'b1; ALUop = ALU_ADD; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls_cur)
                    C_LD:     begin Read = 1'b1; MDRin = 1'b1; end
                    C_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    C_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; end
                    C_BR:     begin Zlowout = CON; PCin = CON; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls_cur)
                    C_LD:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_ST:    begin Write = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized check of control_unit against a step-list model
module tb_control_unit;
    import cpu_pkg::*;

    logic       Clock = 1'b0;
    logic       Clear = 1'b1, CON = 1'b0, Stop = 1'b0, MemReady = 1'b1;
    logic [4:0] Opcode = 5'd0;
    logic       Run;
    logic       PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout;
    logic       PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPortin, CONin;
    logic       Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write;
    logic [4:0] ALUop;

    control_unit dut (
        .Clock(Clock), .Clear(Clear), .Opcode(Opcode), .CON(CON), .Stop(Stop), .MemReady(MemReady),
        .Run(Run), .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout), .BAout(BAout),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
        .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin), .CONin(CONin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .IncPC(IncPC), .Read(Read), .Write(Write), .ALUop(ALUop)
    );

    always #5 Clock = ~Clock;

`ifdef CU_MEMWAIT_EN
    localparam bit MW = 1'b1;
`else
    localparam bit MW = 1'b0;
`endif

    localparam logic [26:0] B_PCOUT = 27'd1 << 0,  B_ZLOWOUT = 27'd1 << 1,  B_ZHIGHOUT = 27'd1 << 2;
    localparam logic [26:0] B_MDROUT = 27'd1 << 3, B_HIOUT = 27'd1 << 4,    B_LOOUT = 27'd1 << 5;
    localparam logic [26:0] B_INPORTOUT = 27'd1 << 6, B_COUT = 27'd1 << 7,  B_BAOUT = 27'd1 << 8;
    localparam logic [26:0] B_PCIN = 27'd1 << 9,   B_IRIN = 27'd1 << 10,    B_MARIN = 27'd1 << 11;
    localparam logic [26:0] B_MDRIN = 27'd1 << 12, B_YIN = 27'd1 << 13,     B_ZIN = 27'd1 << 14;
    localparam logic [26:0] B_HIIN = 27'd1 << 15,  B_LOIN = 27'd1 << 16,    B_OUTPORTIN = 27'd1 << 17;
    localparam logic [26:0] B_CONIN = 27'd1 << 18, B_GRA = 27'd1 << 19,     B_GRB = 27'd1 << 20;
    localparam logic [26:0] B_GRC = 27'd1 << 21,   B_RIN = 27'd1 << 22,     B_ROUT = 27'd1 << 23;
    localparam logic [26:0] B_INCPC = 27'd1 << 24, B_READ = 27'd1 << 25,    B_WRITE = 27'd1 << 26;
    localparam logic [26:0] F_T0 = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
    localparam logic [26:0] F_T1 = B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN;

    typedef struct {
        logic [26:0] mask;
        logic [4:0]  alu;
        bit          mem;
        bit          t0;
        bit          t2;
        bit          br6;
    } step_t;

    typedef enum {M_UNK, M_IDLE, M_RUN, M_HALT} mode_t;

    step_t steps[$];
    mode_t mode = M_UNK;
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;

    task automatic push(input logic [26:0] m, input logic [4:0] a = 5'd0, input bit mem = 0,
                        input bit t0 = 0, input bit t2 = 0, input bit br6 = 0);
        step_t s;
        s.mask = m; s.alu = a; s.mem = mem; s.t0 = t0; s.t2 = t2; s.br6 = br6;
        steps.push_back(s);
    endtask

    task automatic push_fetch();
        push(F_T0, 5'd0, 0, 1, 0);
        push(F_T1, 5'd0, 1, 0, 0);
        push(B_MDROUT | B_IRIN, 5'd0, 0, 0, 1);
    endtask

    // Execute-step list for one instruction, written straight from the opcode table.
    task automatic push_exec(input logic [4:0] op);
        int o = int'(op);
        if (o <= 2) begin
            push(B_GRB | B_BAOUT | B_YIN);
            push(B_COUT | B_ZIN, 5'd3);
            if (o == 1) push(B_ZLOWOUT | B_GRA | B_RIN);
            else        push(B_ZLOWOUT | B_MARIN);
            if (o == 0) begin
                push(B_READ | B_MDRIN, 5'd0, 1);
                push(B_MDROUT | B_GRA | B_RIN);
            end else if (o == 2) begin
                push(B_GRA | B_ROUT | B_MDRIN);
                push(B_WRITE, 5'd0, 1);
            end
        end else if (o <= 14) begin
            push(B_GRB | B_ROUT | B_YIN);
            push(((o <= 11) ? (B_GRC | B_ROUT) : B_COUT) | B_ZIN, op);
            push(B_ZLOWOUT | B_GRA | B_RIN);
        end else if (o <= 16) begin
            push(B_GRA | B_ROUT | B_YIN);
            push(B_GRB | B_ROUT | B_ZIN, op);
            push(B_ZLOWOUT | B_LOIN);
            push(B_ZHIGHOUT | B_HIIN);
        end else if (o <= 18) begin
            push(B_GRB | B_ROUT | B_ZIN, op);
            push(B_ZLOWOUT | B_GRA | B_RIN);
        end else if (o == 19) begin
            push(B_GRA | B_ROUT | B_CONIN);
            push(B_PCOUT | B_YIN);
            push(B_COUT | B_ZIN, 5'd3);
            push(27'd0, 5'd0, 0, 0, 0, 1);
        end else if (o == 20) push(B_GRA | B_ROUT | B_PCIN);
        else if (o == 21) begin
            push(B_PCOUT | B_GRB | B_RIN);
            push(B_GRA | B_ROUT | B_PCIN);
        end
        else if (o == 22) push(B_INPORTOUT | B_GRA | B_RIN);
        else if (o == 23) push(B_GRA | B_ROUT | B_OUTPORTIN);
        else if (o == 24) push(B_HIOUT | B_GRA | B_RIN);
        else if (o == 25) push(B_LOOUT | B_GRA | B_RIN);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [4:0] rop();
        return 5'($urandom_range(0, 31));
    endfunction

    // One clock: drive inputs, compare against model (and optional literal), then step the model.
    task automatic tick(input bit clr, input bit stp, input bit mr, input bit con, input logic [4:0] op,
                        input bit lit = 0, input logic [26:0] lmask = 27'd0,
                        input logic [4:0] lalu = 5'd0, input bit lrun = 1);
        logic [26:0] got, em;
        logic [4:0]  ea;
        bit          er;
        step_t       cur;
        @(negedge Clock);
        Clear = clr; Stop = stp; MemReady = mr; CON = con; Opcode = op;
        #1;
        got = {Write, Read, IncPC, Rout, Rin, Grc, Grb, Gra, CONin, OutPortin, LOin, HIin, Zin, Yin,
               MDRin, MARin, IRin, PCin, BAout, Cout, InPortout, LOout, HIout, MDRout, Zhighout,
               Zlowout, PCout};
        if (mode != M_UNK) begin
            em = 27'd0; ea = 5'd0; er = (mode != M_HALT);
            if (mode == M_RUN) begin
                cur = steps[0];
                em = cur.br6 ? (con ? (B_ZLOWOUT | B_PCIN) : 27'd0) : cur.mask;
                ea = cur.alu;
            end
            check("strobes", 32'(got), 32'(em));
            check("aluop", 32'(ALUop), 32'(ea));
            check("run", 32'(Run), 32'(er));
            check("bus_onehot", 32'($countones(got[8:0]) <= 1), 32'd1);
        end
        if (lit) begin
            check("lit_strobes", 32'(got), 32'(lmask));
            check("lit_aluop", 32'(ALUop), 32'(lalu));
            check("lit_run", 32'(Run), 32'(lrun));
        end
        if (clr) begin
            mode = M_IDLE;
            steps.delete();
        end else if (mode == M_IDLE) begin
            mode = M_RUN;
            push_fetch();
        end else if (mode == M_RUN) begin
            cur = steps[0];
            if (MW && cur.mem && !mr) begin
            end else if (cur.t0 && stp) begin
                mode = M_HALT;
                steps.delete();
            end else begin
                void'(steps.pop_front());
                if (cur.t2) begin
                    if (op == OP_HALT) mode = M_HALT;
                    else push_exec(op);
                end
                if (mode == M_RUN && steps.size() == 0) push_fetch();
            end
        end
        cyc++;
    endtask

    task automatic fetch(input logic [4:0] op);
        tick(0, 0, 1, 1'($urandom), rop(), 1, F_T0);
        tick(0, 0, 1, 1'($urandom), rop(), 1, F_T1);
        tick(0, 0, 1, 1'($urandom), op, 1, B_MDROUT | B_IRIN);
    endtask

    initial begin
        tick(1, 0, 1, 0, 5'd0);
        tick(1, 0, 1, 0, 5'd0);
        tick(0, 0, 1, 0, 5'd0, 1, 27'd0, 5'd0, 1);
        fetch(OP_ADD);
        tick(0, 0, 1, 0, rop(), 1, B_GRB | B_ROUT | B_YIN);
        tick(0, 1, 1, 0, rop(), 1, B_GRC | B_ROUT | B_ZIN, 5'b00011);
        tick(0, 0, 1, 0, rop(), 1, B_ZLOWOUT | B_GRA | B_RIN);

        fetch(OP_BR);
        tick(0, 0, 1, 1, rop(), 1, B_GRA | B_ROUT | B_CONIN);
        tick(0, 0, 1, 1, rop(), 1, B_PCOUT | B_YIN);
        tick(0, 0, 1, 1, rop(), 1, B_COUT | B_ZIN, 5'b00011);
        tick(0, 0, 1, 0, rop(), 1, 27'd0);
        fetch(OP_BR);
        tick(0, 0, 1, 0, rop());
        tick(0, 0, 1, 0, rop());
        tick(0, 0, 1, 0, rop());
        tick(0, 0, 1, 1, rop(), 1, B_ZLOWOUT | B_PCIN);

        fetch(OP_LD);
        tick(0, 0, 1, 0, rop(), 1, B_GRB | B_BAOUT | B_YIN);
        tick(0, 0, 1, 0, rop(), 1, B_COUT | B_ZIN, 5'b00011);
        tick(0, 0, 1, 0, rop(), 1, B_ZLOWOUT | B_MARIN);
`ifdef CU_MEMWAIT_EN
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, rop(), 1, B_READ | B_MDRIN);
`endif
        tick(0, 0, 1, 0, rop(), 1, B_READ | B_MDRIN);
        tick(0, 0, 1, 0, rop(), 1, B_MDROUT | B_GRA | B_RIN);

        tick(0, 1, 1, 0, rop(), 1, F_T0);
        for (int i = 0; i < 20; i++) tick(0, 1'($urandom), 1'($urandom), 1'($urandom), rop(), 1, 27'd0, 5'd0, 0);
        tick(1, 0, 1, 0, rop(), 1, 27'd0, 5'd0, 0);
        tick(0, 0, 1, 0, rop(), 1, 27'd0, 5'd0, 1);

        fetch(OP_HALT);
        for (int i = 0; i < 20; i++) tick(0, 0, 1, 0, rop(), 1, 27'd0, 5'd0, 0);
        tick(1, 0, 1, 0, rop());

        for (int i = 0; i < 4000; i++) begin
            bit clr;
            clr = (mode == M_HALT) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0);
            tick(clr, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, 1'($urandom), rop());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
